palette_ram: RTL and testbench
==============================

// Module: palette_ram
// PURPOSE
//   Programmable colour palette for the VGA pixel pipeline, replacing fixed palette ROMs.
//   Maps a pixel index to an RGB colour through a RAM-backed table with a registered
//   1-cycle lookup, valid pipelining and blanking.
//   After reset (or on request) an internal sequencer loads the default palette.
//   A host write port then recolours individual entries at runtime.
// PARAMETERS
//   INDEX_W  4  index width; palette DEPTH = 2**INDEX_W entries
//   COLOR_W  9  colour width (RGB333 when 9)
// PORTS
//   i_clk         in   1        system clock, all logic on rising edge
//   i_rst_n       in   1        asynchronous active-low reset
//   i_pix_valid   in   1        pixel index valid this cycle
//   i_pix_index   in   INDEX_W  palette index to look up
//   i_blank       in   1        force black (outside active video)
//   o_pix_valid   out  1        o_color valid (i_pix_valid delayed 1 cycle)
//   o_color       out  COLOR_W  looked-up colour
//   i_wr_en       in   1        host write strobe
//   i_wr_addr     in   INDEX_W  host write entry
//   i_wr_data     in   COLOR_W  host write colour
//   o_wr_ready    out  1        1 = host writes accepted this cycle
//   i_reinit      in   1        pulse: reload default palette
//   o_init_busy   out  1        1 while default palette is being loaded
// BEHAVIOUR
//   Reset (async assert, sync release):
//   - o_color=0, o_pix_valid=0, o_wr_ready=0, o_init_busy=1.
//   - FSM=INIT, init counter=0.
//   - RAM contents are not reset; the INIT state fills them.
//   FSM INIT:
//   - Writes default[cnt] to RAM[cnt] each cycle, then cnt++.
//   - When cnt==DEPTH-1 is written, moves to RUN next cycle.
//   - Total DEPTH cycles after reset release.
//   - o_init_busy=1 and o_wr_ready=0 throughout.
//   - Host writes in INIT are dropped, not queued.
//   - i_reinit in INIT is ignored (the load is not restarted).
//   FSM RUN:
//   - o_init_busy=0, o_wr_ready=1.
//   - i_wr_en writes i_wr_data to RAM[i_wr_addr] at the clock edge.
//   - i_reinit -> INIT with cnt=0. A write in that same cycle is performed, then overwritten.
//   Default table (index: colour), entries >=14 are 0:
//   - 0:000  1:00B  2:027  3:078  4:0CF  5:124  6:1C0
//   - 7:1CC  8:1E0  9:1E4  10:1E7  11:1F4  12:1F8  13:1FF
//   - Values are COLOR_W-bit, zero-extended or truncated from 9 bits.
//   Pixel path (latency exactly 1 cycle):
//   - o_pix_valid <= i_pix_valid every cycle.
//   - When i_pix_valid=1: o_color <= (i_blank | o_init_busy) ? 0 : RAM[i_pix_index].
//   - When i_pix_valid=0: o_color holds its previous value.
//   - Read-before-write: a lookup and a host write to the same entry in one cycle
//     returns the OLD colour; the new colour is visible from the next lookup.
//   - A lookup on the cycle FSM enters RUN returns 0 (busy sampled as 1 that cycle).
//   Reset mid-operation (INIT or RUN): outputs return to reset values immediately;
//   the full INIT reload restarts once reset is released.
//   Widths: no arithmetic on colours. The init counter is INDEX_W bits and never wraps
//   (exits at DEPTH-1).
// TESTING
//   1. Reset release, i_pix_valid=1, index=13:
//      -> o_init_busy=1 for 16 cycles, o_color=0 meanwhile;
//      -> after busy falls, o_color=9'h1FF 1 cycle later.
//   2. Sweep index 0..15 in RUN -> o_color matches the default table,
//      o_pix_valid lags i_pix_valid by 1.
//   3. Write addr 5 = 9'h155 with a same-cycle lookup of 5:
//      -> that lookup returns 9'h124, the next lookup returns 9'h155.
//   4. i_blank=1 with index 13 -> o_color=0.
//      Drop i_pix_valid -> o_color holds its last value.
//   5. In RUN, pulse i_reinit after writing addr 2 = 9'h0AA:
//      -> busy high 16 cycles, writes during busy dropped (o_wr_ready=0);
//      -> addr 2 reads 9'h027 afterwards.
//   6. Assert i_rst_n=0 mid-INIT (cnt=7) and mid-RUN:
//      -> outputs go to reset values asynchronously;
//      -> after release, INIT takes a full 16 cycles.

Source files
------------

// File: rtl/palette_ram.sv
// Programmable VGA colour palette: RAM-backed index-to-colour lookup with a 1-cycle
// registered read, blanking, and a sequencer that loads the default palette.
module palette_ram #(
    parameter int INDEX_W = 4,
    parameter int COLOR_W = 9
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_pix_valid,
    input  logic [INDEX_W-1:0] i_pix_index,
    input  logic               i_blank,
    output logic               o_pix_valid,
    output logic [COLOR_W-1:0] o_color,
    input  logic               i_wr_en,
    input  logic [INDEX_W-1:0] i_wr_addr,
    input  logic [COLOR_W-1:0] i_wr_data,
    output logic               o_wr_ready,
    input  logic               i_reinit,
    output logic               o_init_busy,
    output logic               o_dbg_state
);

    localparam int DEPTH = 2 ** INDEX_W;
    localparam logic [INDEX_W-1:0] LAST = INDEX_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e             state_q;
    logic [INDEX_W-1:0] cnt_q;
    logic               busy_q;
    logic               ready_q;
    logic               valid_q;
    logic [COLOR_W-1:0] color_q;
    logic [COLOR_W-1:0] mem_q [DEPTH];

    logic               mem_we_d;
    logic [INDEX_W-1:0] mem_wa_d;
    logic [COLOR_W-1:0] mem_wd_d;

    function automatic logic [COLOR_W-1:0] default_color(input logic [INDEX_W-1:0] idx);
        logic [8:0] c;
        case (int'(idx))
            0:       c = 9'h000;
            1:       c = 9'h00B;
            2:       c = 9'h027;
            3:       c = 9'h078;
            4:       c = 9'h0CF;
            5:       c = 9'h124;
            6:       c = 9'h1C0;
            7:       c = 9'h1CC;
            8:       c = 9'h1E0;
            9:       c = 9'h1E4;
            10:      c = 9'h1E7;
            11:      c = 9'h1F4;
            12:      c = 9'h1F8;
            13:      c = 9'h1FF;
            default: c = 9'h000;
        endcase
        return COLOR_W'(c);
    endfunction

    // Single RAM write port shared by the init sequencer and the host.
    always_comb begin
        mem_we_d = 1'b0;
        mem_wa_d = '0;
        mem_wd_d = '0;
        if (state_q == ST_INIT) begin
            mem_we_d = 1'b1;
            mem_wa_d = cnt_q;
            mem_wd_d = default_color(cnt_q);
        end else if (i_wr_en) begin
            mem_we_d = 1'b1;
            mem_wa_d = i_wr_addr;
            mem_wd_d = i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we_d) begin
            mem_q[mem_wa_d] <= mem_wd_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    // Counter stops at the last entry rather than wrapping.
                    if (cnt_q == LAST) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (i_reinit) begin
                        state_q <= ST_INIT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Reads sample the RAM before this edge's write lands (read-before-write).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            color_q <= '0;
        end else begin
            valid_q <= i_pix_valid;
            if (i_pix_valid) begin
                color_q <= (i_blank || busy_q) ? '0 : mem_q[i_pix_index];
            end
        end
    end

    assign o_pix_valid = valid_q;
    assign o_color     = color_q;
    assign o_wr_ready  = ready_q;
    assign o_init_busy = busy_q;
    assign o_dbg_state = (state_q == ST_RUN);

endmodule

// File: tb/tb_palette_ram.sv
// Bench for palette_ram: hand-derived vector table plus a per-cycle reference model
// driven by directed sequences and random traffic.
module tb_palette_ram;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_pix_valid;
    logic [3:0] i_pix_index;
    logic       i_blank;
    logic       o_pix_valid;
    logic [8:0] o_color;
    logic       i_wr_en;
    logic [3:0] i_wr_addr;
    logic [8:0] i_wr_data;
    logic       o_wr_ready;
    logic       i_reinit;
    logic       o_init_busy;
    logic       o_dbg_state;

    palette_ram #(.INDEX_W(4), .COLOR_W(9)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_pix_valid (i_pix_valid),
        .i_pix_index (i_pix_index),
        .i_blank     (i_blank),
        .o_pix_valid (o_pix_valid),
        .o_color     (o_color),
        .i_wr_en     (i_wr_en),
        .i_wr_addr   (i_wr_addr),
        .i_wr_data   (i_wr_data),
        .o_wr_ready  (o_wr_ready),
        .i_reinit    (i_reinit),
        .o_init_busy (o_init_busy),
        .o_dbg_state (o_dbg_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    localparam logic [8:0] DEF [16] = '{
        9'h000, 9'h00B, 9'h027, 9'h078, 9'h0CF, 9'h124, 9'h1C0, 9'h1CC,
        9'h1E0, 9'h1E4, 9'h1E7, 9'h1F4, 9'h1F8, 9'h1FF, 9'h000, 9'h000
    };

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: palette contents, cycles of loading left, expected outputs.
    logic [8:0] m_mem [16];
    int         m_init_left;
    logic [8:0] m_color;
    logic       m_valid;

    typedef struct {
        logic       pv;
        logic [3:0] idx;
        logic       blank;
        logic       we;
        logic [3:0] wa;
        logic [8:0] wd;
        logic [8:0] exp_color;
        logic       exp_valid;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_init_left = 16;
        m_color     = 9'h000;
        m_valid     = 1'b0;
        for (int i = 0; i < 16; i++) m_mem[i] = DEF[i];
    endtask

    task automatic model_step();
        bit busy;
        busy    = (m_init_left > 0);
        m_valid = i_pix_valid;
        if (i_pix_valid) m_color = (i_blank || busy) ? 9'h000 : m_mem[i_pix_index];
        if (busy) begin
            m_init_left--;
        end else begin
            if (i_wr_en) m_mem[i_wr_addr] = i_wr_data;
            if (i_reinit) begin
                m_init_left = 16;
                for (int i = 0; i < 16; i++) m_mem[i] = DEF[i];
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge i_clk);
        #1;
        check("model_color", 32'(o_color), 32'(m_color));
        check("model_valid", 32'(o_pix_valid), 32'(m_valid));
        check("model_busy", 32'(o_init_busy), 32'(m_init_left > 0));
        check("model_ready", 32'(o_wr_ready), 32'(m_init_left == 0));
    endtask

    task automatic idle_inputs();
        i_pix_valid = 1'b0;
        i_pix_index = 4'd0;
        i_blank     = 1'b0;
        i_wr_en     = 1'b0;
        i_wr_addr   = 4'd0;
        i_wr_data   = 9'h000;
        i_reinit    = 1'b0;
    endtask

    // Asserts reset between edges and checks the outputs react without a clock.
    task automatic async_reset(input string tag);
        #2;
        i_rst_n = 1'b0;
        #1;
        check({tag, "_rst_color"}, 32'(o_color), 32'h0);
        check({tag, "_rst_valid"}, 32'(o_pix_valid), 32'h0);
        check({tag, "_rst_busy"}, 32'(o_init_busy), 32'h1);
        check({tag, "_rst_ready"}, 32'(o_wr_ready), 32'h0);
        model_reset();
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        i_rst_n = 1'b0;
        model_reset();
        #17;
        check("reset_busy", 32'(o_init_busy), 32'h1);
        check("reset_ready", 32'(o_wr_ready), 32'h0);
        check("reset_color", 32'(o_color), 32'h0);
        check("reset_valid", 32'(o_pix_valid), 32'h0);

        // Reset release with a continuous lookup of entry 13.
        i_pix_valid = 1'b1;
        i_pix_index = 4'd13;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            cycle();
            check("t1_busy", 32'(o_init_busy), 32'(k < 16));
            check("t1_color_zero", 32'(o_color), 32'h0);
        end
        cycle();
        check("t1_color_13", 32'(o_color), 32'h1FF);

        // Vector table: sweep, write-vs-read collision, blank, hold.
        for (int i = 0; i < 16; i++)
            vecs.push_back('{1'b1, 4'(i), 1'b0, 1'b0, 4'd0, 9'h000, DEF[i], 1'b1});
        vecs.push_back('{1'b1, 4'd13, 1'b0, 1'b0, 4'd0, 9'h000, 9'h1FF, 1'b1});
        vecs.push_back('{1'b0, 4'd3, 1'b0, 1'b0, 4'd0, 9'h000, 9'h1FF, 1'b0});
        vecs.push_back('{1'b1, 4'd5, 1'b0, 1'b1, 4'd5, 9'h155, 9'h124, 1'b1});
        vecs.push_back('{1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 9'h000, 9'h155, 1'b1});
        vecs.push_back('{1'b1, 4'd13, 1'b1, 1'b0, 4'd0, 9'h000, 9'h000, 1'b1});
        vecs.push_back('{1'b0, 4'd13, 1'b0, 1'b0, 4'd0, 9'h000, 9'h000, 1'b0});
        vecs.push_back('{1'b1, 4'd10, 1'b0, 1'b1, 4'd10, 9'h0F0, 9'h1E7, 1'b1});
        vecs.push_back('{1'b0, 4'd10, 1'b0, 1'b0, 4'd0, 9'h000, 9'h1E7, 1'b0});
        vecs.push_back('{1'b1, 4'd10, 1'b0, 1'b0, 4'd0, 9'h000, 9'h0F0, 1'b1});
        foreach (vecs[v]) begin
            i_pix_valid = vecs[v].pv;
            i_pix_index = vecs[v].idx;
            i_blank     = vecs[v].blank;
            i_wr_en     = vecs[v].we;
            i_wr_addr   = vecs[v].wa;
            i_wr_data   = vecs[v].wd;
            cycle();
            check($sformatf("vec%0d_color", v), 32'(o_color), 32'(vecs[v].exp_color));
            check($sformatf("vec%0d_valid", v), 32'(o_pix_valid), 32'(vecs[v].exp_valid));
        end
        idle_inputs();

        // Recolour entry 2, then reload defaults; writes and re-pulses while busy are ignored.
        i_wr_en = 1'b1; i_wr_addr = 4'd2; i_wr_data = 9'h0AA;
        cycle();
        idle_inputs();
        i_pix_valid = 1'b1; i_pix_index = 4'd2;
        cycle();
        check("t5_written", 32'(o_color), 32'h0AA);
        i_reinit = 1'b1;
        cycle();
        check("t5_busy_rise", 32'(o_init_busy), 32'h1);
        i_reinit = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            i_wr_en   = 1'b1;
            i_wr_addr = 4'd2;
            i_wr_data = 9'($urandom_range(0, 511));
            i_reinit  = (k == 8);
            cycle();
            check("t5_ready_low", 32'(o_wr_ready), 32'(k == 16));
            check("t5_busy", 32'(o_init_busy), 32'(k < 16));
            check("t5_color_zero", 32'(o_color), 32'h0);
        end
        idle_inputs();
        i_pix_valid = 1'b1; i_pix_index = 4'd2;
        cycle();
        check("t5_default_back", 32'(o_color), 32'h027);

        // Reset mid-RUN with a non-zero colour on the output, then a full reload.
        i_pix_index = 4'd13;
        cycle();
        check("t6_run_color", 32'(o_color), 32'h1FF);
        async_reset("t6_run");
        for (int k = 1; k <= 7; k++) cycle();
        check("t6_init_busy", 32'(o_init_busy), 32'h1);
        async_reset("t6_init");
        for (int k = 1; k <= 16; k++) begin
            cycle();
            check("t6_reload_busy", 32'(o_init_busy), 32'(k < 16));
        end
        cycle();
        check("t6_reload_color", 32'(o_color), 32'h1FF);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            i_pix_valid = ($urandom_range(0, 3) != 0);
            i_pix_index = 4'($urandom_range(0, 15));
            i_blank     = ($urandom_range(0, 7) == 0);
            i_wr_en     = ($urandom_range(0, 2) == 0);
            i_wr_addr   = 4'($urandom_range(0, 15));
            i_wr_data   = 9'($urandom_range(0, 511));
            i_reinit    = ($urandom_range(0, 59) == 0);
            cycle();
        end
        idle_inputs();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
